mem_loop_seq: RTL and testbench

//  Hardware sequencer for a single-port memory/register-file fill. Replaces testbench-style
//  for/while/repeat init loops with a synthesizable FSM: clear, strided index fill, or

---
 rtl/mem_loop_seq_pkg.sv | 21 ++
 rtl/mem_loop_seq_if.sv | 36 +++
 rtl/mem_loop_seq_addr_gen.sv | 32 +++
 rtl/mem_loop_seq.sv | 138 +++++++++++++
 tb/tb_mem_loop_seq.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/mem_loop_seq_pkg.sv
// Shared types for the memory fill / accumulate sequencer.
package mem_loop_seq_pkg;

   typedef enum logic [1:0] {
      MODE_CLEAR = 2'b00,
      MODE_INDEX = 2'b01,
      MODE_ACCUM = 2'b10,
      MODE_RSVD  = 2'b11
   } mode_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FILL,
      ST_ACC,
      ST_ACC_WR,
      ST_DONE
   } state_e;

   localparam int REP_W = 8;

endpackage

// File: rtl/mem_loop_seq_if.sv
// Command and memory write-port bundle for mem_loop_seq.
interface mem_loop_seq_if
   import mem_loop_seq_pkg::*;
#(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 8
);
   logic              start;
   logic [1:0]        mode;
   logic [ADDR_W-1:0] stride;
   logic [ADDR_W:0]   limit;
   logic [DATA_W-1:0] acc_a;
   logic [DATA_W-1:0] acc_b;
   logic [REP_W-1:0]  rep_cnt;
   logic              mem_ready;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              busy;
   logic              done;
   logic              err;

   modport master (
      output start, mode, stride, limit,
      output acc_a, acc_b, rep_cnt, mem_ready,
      input  mem_we, mem_addr, mem_wdata,
      input  busy, done, err
   );

   modport slave (
      input  start, mode, stride, limit,
      input  acc_a, acc_b, rep_cnt, mem_ready,
      output mem_we, mem_addr, mem_wdata,
      output busy, done, err
   );
endinterface

// File: rtl/mem_loop_seq_addr_gen.sv
// Fill index generator: one extra index bit so overshoot ends the loop.
module mem_loop_addr_gen
   import mem_loop_seq_pkg::*;
#(
   parameter int ADDR_W = 4
) (
   input  logic              Clk,
   input  logic              Rst,
   input  logic              i_load,
   input  logic              i_adv,
   input  logic [ADDR_W-1:0] i_stride,
   input  logic [ADDR_W:0]   i_limit,
   output logic [ADDR_W:0]   o_idx,
   output logic              o_last
);
   logic [ADDR_W:0] r_idx;
   logic [ADDR_W:0] w_step;

   always_comb begin
      w_step = {1'b0, i_stride};
      if (i_stride == '0) w_step = (ADDR_W+1)'(1);
   end

   always_ff @(posedge Clk) begin
      if (Rst)        r_idx <= '0;
      else if (i_load) r_idx <= '0;
      else if (i_adv)  r_idx <= r_idx + w_step;
   end

   assign o_idx  = r_idx;
   assign o_last = (r_idx >= i_limit);
endmodule

// File: rtl/mem_loop_seq.sv
// Clear / strided-index fill / repeat-accumulate write sequencer.
// Optional MEM_LOOP_SEQ_WRCNT_EN adds o_wr_count (accepted writes).
module mem_loop_seq
   import mem_loop_seq_pkg::*;
#(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 8
) (
   input logic Clk,
   input logic Rst,
   mem_loop_seq_if.slave io_bus
`ifdef MEM_LOOP_SEQ_WRCNT_EN
   ,
   output logic [ADDR_W:0] o_wr_count
`endif
);
   state_e            r_state;
   state_e            w_nxt;
   mode_e             r_mode;
   logic [ADDR_W-1:0] r_stride;
   logic [ADDR_W:0]   r_limit;
   logic [DATA_W-1:0] r_acc;
   logic [DATA_W-1:0] r_accb;
   logic [REP_W-1:0]  r_cnt;
   logic              r_err;
   logic              w_start;
   logic              w_load;
   logic              w_adv;
   logic              w_we;
   logic [ADDR_W-1:0] w_addr;
   logic [DATA_W-1:0] w_wdata;
   logic [ADDR_W-1:0] w_stride;
   logic [ADDR_W:0]   w_idx;
   logic              w_last;

   assign w_start  = (r_state == ST_IDLE) && io_bus.start;
   assign w_stride = (r_mode == MODE_CLEAR) ? ADDR_W'(1) : r_stride;

   mem_loop_addr_gen #(.ADDR_W(ADDR_W)) u_addr (
      .Clk      (Clk),
      .Rst      (Rst),
      .i_load   (w_load),
      .i_adv    (w_adv),
      .i_stride (w_stride),
      .i_limit  (r_limit),
      .o_idx    (w_idx),
      .o_last   (w_last)
   );

   always_comb begin
      w_nxt   = r_state;
      w_load  = 1'b0;
      w_adv   = 1'b0;
      w_we    = 1'b0;
      w_addr  = '0;
      w_wdata = '0;
      unique case (r_state)
         ST_IDLE: begin
            if (io_bus.start) begin
               w_load = 1'b1;
               unique case (mode_e'(io_bus.mode))
                  MODE_CLEAR, MODE_INDEX: w_nxt = ST_FILL;
                  MODE_ACCUM:             w_nxt = ST_ACC;
                  default:                w_nxt = ST_DONE;
               endcase
            end
         end
         ST_FILL: begin
            if (w_last) begin
               w_nxt = ST_DONE;
            end else begin
               w_we   = 1'b1;
               w_addr = w_idx[ADDR_W-1:0];
               if (r_mode == MODE_INDEX) w_wdata = DATA_W'(w_idx);
               w_adv  = io_bus.mem_ready;
            end
         end
         ST_ACC: begin
            if (r_cnt == '0) w_nxt = ST_ACC_WR;
         end
         ST_ACC_WR: begin
            w_we    = 1'b1;
            w_wdata = r_acc;
            if (io_bus.mem_ready) w_nxt = ST_DONE;
         end
         ST_DONE: w_nxt = ST_IDLE;
         default: w_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         r_state  <= ST_IDLE;
         r_mode   <= MODE_CLEAR;
         r_stride <= '0;
         r_limit  <= '0;
         r_acc    <= '0;
         r_accb   <= '0;
         r_cnt    <= '0;
         r_err    <= 1'b0;
      end else begin
         r_state <= w_nxt;
         if (w_start) begin
            r_mode   <= mode_e'(io_bus.mode);
            r_stride <= io_bus.stride;
            r_limit  <= io_bus.limit;
            r_acc    <= io_bus.acc_a;
            r_accb   <= io_bus.acc_b;
            r_cnt    <= io_bus.rep_cnt;
            r_err    <= (mode_e'(io_bus.mode) == MODE_RSVD);
         end else if (r_state == ST_ACC && r_cnt != '0) begin
            r_acc <= r_acc + ~r_accb;
            r_cnt <= r_cnt - REP_W'(1);
         end
      end
   end

`ifdef MEM_LOOP_SEQ_WRCNT_EN
   logic [ADDR_W:0] r_wr_cnt;

   always_ff @(posedge Clk) begin
      if (Rst)                          r_wr_cnt <= '0;
      else if (w_start)                 r_wr_cnt <= '0;
      else if (w_we && io_bus.mem_ready) r_wr_cnt <= r_wr_cnt + (ADDR_W+1)'(1);
   end

   assign o_wr_count = r_wr_cnt;
`endif

   assign io_bus.mem_we    = w_we;
   assign io_bus.mem_addr  = w_addr;
   assign io_bus.mem_wdata = w_wdata;
   assign io_bus.busy      = (r_state == ST_FILL) ||
                             (r_state == ST_ACC)  ||
                             (r_state == ST_ACC_WR);
   assign io_bus.done      = (r_state == ST_DONE);
   assign io_bus.err       = r_err;
endmodule

// File: tb/tb_mem_loop_seq.sv
// Bench for mem_loop_seq: vector table plus stall, busy-start and reset cases.
module tb_mem_loop_seq;
   import mem_loop_seq_pkg::*;

   localparam int AW = 4;
   localparam int DW = 8;

   logic Clk = 1'b0;
   logic Rst = 1'b1;
   always #5 Clk = ~Clk;

   mem_loop_seq_if #(.ADDR_W(AW), .DATA_W(DW)) bus();

`ifdef MEM_LOOP_SEQ_WRCNT_EN
   logic [AW:0] wr_count;
`endif

   mem_loop_seq #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .Clk    (Clk),
      .Rst    (Rst),
      .io_bus (bus)
`ifdef MEM_LOOP_SEQ_WRCNT_EN
      ,
      .o_wr_count (wr_count)
`endif
   );

   typedef struct packed {
      logic [AW-1:0] a;
      logic [DW-1:0] d;
   } wr_t;

   typedef struct {
      logic [1:0]    mode;
      logic [AW-1:0] stride;
      logic [AW:0]   limit;
      logic [DW-1:0] a;
      logic [DW-1:0] b;
      logic [7:0]    rep;
      int            n;
      int            lat;
      logic          err;
   } vec_t;

   wr_t  q[$];
   int   n_chk = 0;
   int   n_err = 0;
   int   n_wr  = 0;
   vec_t vt[11];

   task automatic check(input string nm, input longint act, input longint exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   // scoreboard: every accepted write must match the head of the queue
   always @(negedge Clk) begin
      if (!Rst && bus.mem_we && bus.mem_ready) begin
         n_wr++;
         if (q.size() == 0) begin
            check("unexpected_write", {bus.mem_addr, bus.mem_wdata}, -1);
         end else begin
            wr_t w;
            w = q.pop_front();
            check("write_addr_data", {bus.mem_addr, bus.mem_wdata}, w);
         end
      end
   end

   task automatic push_model(input vec_t v);
      wr_t w;
      int step;
      logic [DW-1:0] acc;
      if (v.mode == 2'd2) begin
         acc = v.a;
         for (int i = 0; i < int'(v.rep); i++) acc = acc + ~v.b;
         w.a = '0;
         w.d = acc;
         q.push_back(w);
      end else if (v.mode != 2'd3) begin
         step = (v.mode == 2'd0) ? 1 : ((v.stride == 0) ? 1 : int'(v.stride));
         for (int i = 0; i < int'(v.limit); i += step) begin
            w.a = AW'(i);
            w.d = (v.mode == 2'd1) ? DW'(i) : '0;
            q.push_back(w);
         end
      end
   endtask

   task automatic drive(input vec_t v);
      bus.mode    = v.mode;
      bus.stride  = v.stride;
      bus.limit   = v.limit;
      bus.acc_a   = v.a;
      bus.acc_b   = v.b;
      bus.rep_cnt = v.rep;
      bus.start   = 1'b1;
   endtask

   task automatic wait_done(inout int lat);
      while (!bus.done && lat < 400) begin
         tick();
         lat++;
      end
      if (!bus.done) check("done_timeout", lat, -1);
   endtask

   initial begin
      int lat;
      vec_t v;
      bus.start = 0; bus.mode = 0; bus.stride = 0; bus.limit = 0;
      bus.acc_a = 0; bus.acc_b = 0; bus.rep_cnt = 0; bus.mem_ready = 1;

      vt[0]  = '{2'd0, 4'd0,  5'd16, 8'h00, 8'h00, 8'd0,  16, 18, 1'b0};
      vt[1]  = '{2'd1, 4'd2,  5'd10, 8'h00, 8'h00, 8'd0,  5,  7,  1'b0};
      vt[2]  = '{2'd1, 4'd3,  5'd16, 8'h00, 8'h00, 8'd0,  6,  8,  1'b0};
      vt[3]  = '{2'd2, 4'd0,  5'd0,  8'h01, 8'h00, 8'd10, 1,  13, 1'b0};
      vt[4]  = '{2'd0, 4'd0,  5'd0,  8'h00, 8'h00, 8'd0,  0,  2,  1'b0};
      vt[5]  = '{2'd3, 4'd0,  5'd8,  8'h00, 8'h00, 8'd0,  0,  1,  1'b1};
      vt[6]  = '{2'd2, 4'd0,  5'd0,  8'h5A, 8'h07, 8'd0,  1,  3,  1'b0};
      vt[7]  = '{2'd2, 4'd0,  5'd0,  8'h10, 8'h03, 8'd4,  1,  7,  1'b0};
      vt[8]  = '{2'd1, 4'd15, 5'd16, 8'h00, 8'h00, 8'd0,  2,  4,  1'b0};
      vt[9]  = '{2'd1, 4'd5,  5'd11, 8'h00, 8'h00, 8'd0,  3,  5,  1'b0};
      vt[10] = '{2'd0, 4'd9,  5'd1,  8'h00, 8'h00, 8'd0,  1,  3,  1'b0};

      repeat (3) tick();
      check("reset_outputs",
            {bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.busy, bus.done, bus.err}, 0);
      Rst = 1'b0;
      tick();
      check("idle_outputs",
            {bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.busy, bus.done, bus.err}, 0);
`ifdef MEM_LOOP_SEQ_WRCNT_EN
      check("wr_count_reset", wr_count, 0);
`endif

      for (int k = 0; k < 11; k++) begin
         v = vt[k];
         n_wr = 0;
         push_model(v);
         drive(v);
         tick();
         bus.start = 1'b0;
         lat = 1;
         check($sformatf("v%0d_busy_c1", k), bus.busy, (v.mode != 2'd3));
         wait_done(lat);
         check($sformatf("v%0d_latency", k), lat, v.lat);
         check($sformatf("v%0d_err", k), bus.err, v.err);
         check($sformatf("v%0d_busy_done", k), bus.busy, 0);
         check($sformatf("v%0d_nwrites", k), n_wr, v.n);
         check($sformatf("v%0d_queue_left", k), q.size(), 0);
`ifdef MEM_LOOP_SEQ_WRCNT_EN
         check($sformatf("v%0d_wr_count", k), wr_count, v.n);
`endif
         tick();
         check($sformatf("v%0d_done_pulse", k), bus.done, 0);
      end

      // backpressure on addr 1, stride 0 behaves as 1
      v = '{2'd1, 4'd0, 5'd4, 8'h00, 8'h00, 8'd0, 4, 9, 1'b0};
      n_wr = 0;
      push_model(v);
      drive(v);
      tick();
      bus.start = 1'b0;
      lat = 1;
      tick();
      lat++;
      bus.mem_ready = 1'b0;
      for (int s = 0; s < 3; s++) begin
         check($sformatf("stall%0d_hold", s),
               {bus.mem_we, bus.mem_addr, bus.mem_wdata}, {1'b1, 4'd1, 8'd1});
         tick();
         lat++;
      end
      bus.mem_ready = 1'b1;
      wait_done(lat);
      check("stall_latency", lat, 9);
      check("stall_nwrites", n_wr, 4);
      check("stall_queue_left", q.size(), 0);
      tick();

      // start while busy must be ignored
      v = '{2'd0, 4'd0, 5'd8, 8'h00, 8'h00, 8'd0, 8, 10, 1'b0};
      n_wr = 0;
      push_model(v);
      drive(v);
      tick();
      bus.start = 1'b0;
      lat = 1;
      tick();
      lat++;
      bus.mode = 2'd2;
      bus.start = 1'b1;
      tick();
      lat++;
      bus.start = 1'b0;
      wait_done(lat);
      check("busy_start_latency", lat, 10);
      check("busy_start_nwrites", n_wr, 8);
      check("busy_start_queue", q.size(), 0);
      tick();
      check("busy_start_idle", {bus.busy, bus.done, bus.mem_we}, 0);

      // reset in the middle of a fill drops the pending write
      v = '{2'd1, 4'd1, 5'd16, 8'h00, 8'h00, 8'd0, 16, 18, 1'b0};
      n_wr = 0;
      drive(v);
      q.push_back(wr_t'{4'd0, 8'd0});
      q.push_back(wr_t'{4'd1, 8'd1});
      tick();
      bus.start = 1'b0;
      tick();
      tick();
      Rst = 1'b1;
      tick();
      check("rst_fill_outputs",
            {bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.busy, bus.done, bus.err}, 0);
      check("rst_fill_nwrites", n_wr, 2);
      check("rst_fill_queue", q.size(), 0);
`ifdef MEM_LOOP_SEQ_WRCNT_EN
      check("rst_fill_wr_count", wr_count, 0);
`endif
      Rst = 1'b0;
      tick();
      check("rst_fill_idle", {bus.busy, bus.done, bus.mem_we}, 0);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end
endmodule
